// File: rtl/led_event_blinker_if.sv
// Purpose: groups the event-side and LED-side signals of led_event_blinker.
// Ports: pulse_in/clr_pending (control -> blinker), led_out/busy/pending/overflow (blinker -> board/status).
// Modports: master = control logic / bench side, slave = blinker side.
interface led_event_blinker_if #(
  parameter int PEND_W = 4
);
  logic              pulse_in;
  logic              clr_pending;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output pulse_in, clr_pending,
    input  led_out, busy, pending, overflow
  );

  modport slave (
    input  pulse_in, clr_pending,
    output led_out, busy, pending, overflow
  );
endinterface

// File: rtl/led_event_blinker.sv
// Purpose: turns 1-cycle event strobes into LED blinks (ON_CYCLES high, OFF_CYCLES low gap), queueing extras.
// Latency: pulse_in sampled at edge k while idle drives led_out high right after edge k.
// Backpressure: none; events beyond 2**PEND_W-1 queued are dropped and flagged by a 1-cycle overflow.
// Ports: clk_in, rst (async active-low), bus (slave): pulse_in, clr_pending in; led_out, busy, pending, overflow out.
module led_event_blinker #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int PEND_W     = 4
) (
  input  logic                 clk_in,
  input  logic                 rst,
  led_event_blinker_if.slave   bus
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  // Keep at least one timer bit so degenerate 1-cycle settings still elaborate.
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              led_q, led_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;

  logic avail;
  logic on_end;
  logic off_end;
  logic start;

  always_comb begin
    avail   = (pending_q != '0) | bus.pulse_in;
    on_end  = (timer_q == TW'(ON_CYCLES - 1));
    off_end = (timer_q == TW'(OFF_CYCLES - 1));
    // A clear in the same cycle cancels any new blink start.
    start   = avail & ~bus.clr_pending &
              ((state_q == ST_IDLE) | ((state_q == ST_OFF) & off_end));
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    led_d      = led_q;
    pending_d  = pending_q;
    overflow_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        led_d = 1'b0;
        if (start) begin
          state_d = ST_ON;
          led_d   = 1'b1;
          timer_d = '0;
        end
      end
      ST_ON: begin
        if (on_end) begin
          state_d = ST_OFF;
          led_d   = 1'b0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_OFF: begin
        if (off_end) begin
          timer_d = '0;
          if (start) begin
            state_d = ST_ON;
            led_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = 1'b0;
        timer_d = '0;
      end
    endcase

    // Queue update: clear wins; a pulse that starts a blink itself nets to zero.
    if (bus.clr_pending) begin
      pending_d = '0;
    end else if ((pending_q == PEND_MAX) && bus.pulse_in && !start) begin
      overflow_d = 1'b1;
    end else begin
      pending_d = pending_q + PEND_W'(bus.pulse_in) - PEND_W'(start);
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      led_q      <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      led_q      <= led_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.led_out  = led_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_led_event_blinker.sv
module tb_led_event_blinker;

  localparam int ON  = 4;
  localparam int OFF = 3;
  localparam int PW  = 2;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;

  always #5 clk_in = ~clk_in;

  led_event_blinker_if #(.PEND_W(PW)) bus ();

  led_event_blinker #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .PEND_W    (PW)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int rises;
  logic prev_led;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for one edge, then sample 1 time unit after it.
  task automatic step(input logic p, input logic c);
    bus.pulse_in    = p;
    bus.clr_pending = c;
    @(posedge clk_in);
    #1;
    bus.pulse_in    = 1'b0;
    bus.clr_pending = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_led"},  32'(bus.led_out), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy),    32'd0);
    chk({tag, "_pend"}, 32'(bus.pending), 32'd0);
  endtask

  initial begin
    bus.pulse_in    = 1'b0;
    bus.clr_pending = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk_idle("reset");
    chk("reset_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk_idle("post_reset");

    // Single pulse: led high after edges 0..3, busy after edges 0..6
    for (int e = 0; e < 10; e++) begin
      step(e == 0, 1'b0);
      chk($sformatf("single_led_e%0d", e),  32'(bus.led_out), 32'(e <= 3));
      chk($sformatf("single_busy_e%0d", e), 32'(bus.busy),    32'(e <= 6));
      chk($sformatf("single_pend_e%0d", e), 32'(bus.pending), 32'd0);
    end

    // Pulses at edges 0,2,3: three blinks, starts at edges 0,7,14, idle after 21
    for (int e = 0; e < 23; e++) begin
      step(e == 0 || e == 2 || e == 3, 1'b0);
      chk($sformatf("three_led_e%0d", e), 32'(bus.led_out),
          32'((e <= 3) || (e >= 7 && e <= 10) || (e >= 14 && e <= 17)));
      chk($sformatf("three_busy_e%0d", e), 32'(bus.busy), 32'(e <= 20));
      chk($sformatf("three_pend_e%0d", e), 32'(bus.pending),
          (e < 2) ? 32'd0 : (e == 2) ? 32'd1 : (e < 7) ? 32'd2 : (e < 14) ? 32'd1 : 32'd0);
    end

    // Saturation: start at 0, extras at 1,2,3,4,6 -> drops at 4 and 6, 4 blinks
    rises    = 0;
    prev_led = 1'b0;
    for (int e = 0; e < 40; e++) begin
      step(e == 0 || e == 1 || e == 2 || e == 3 || e == 4 || e == 6, 1'b0);
      chk($sformatf("sat_ovf_e%0d", e), 32'(bus.overflow), 32'(e == 4 || e == 6));
      if (e <= 7)
        chk($sformatf("sat_pend_e%0d", e), 32'(bus.pending),
            (e == 0) ? 32'd0 : (e == 1) ? 32'd1 : (e == 2) ? 32'd2 : (e < 7) ? 32'd3 : 32'd2);
      if (bus.led_out && !prev_led) rises++;
      prev_led = bus.led_out;
    end
    chk("sat_blinks", 32'(rises), 32'd4);
    chk_idle("sat_end");

    // Pulse on last OFF cycle (edge 7) with empty queue: back-to-back blink
    for (int e = 0; e < 13; e++) begin
      step(e == 0 || e == 7, 1'b0);
      chk($sformatf("b2b_led_e%0d", e), 32'(bus.led_out),
          32'((e <= 3) || (e >= 7 && e <= 10)));
      chk($sformatf("b2b_busy_e%0d", e), 32'(bus.busy), 32'd1);
      chk($sformatf("b2b_pend_e%0d", e), 32'(bus.pending), 32'd0);
    end
    step(1'b0, 1'b0);
    chk("b2b_busy_e13", 32'(bus.busy), 32'd1);
    step(1'b0, 1'b0);
    chk_idle("b2b_end");

    // Clear with pending=2 mid-blink, simultaneous pulse dropped
    for (int e = 0; e < 12; e++) begin
      step(e <= 3, e == 3);
      chk($sformatf("clr_pend_e%0d", e), 32'(bus.pending),
          (e == 0) ? 32'd0 : (e == 1) ? 32'd1 : (e == 2) ? 32'd2 : 32'd0);
      chk($sformatf("clr_ovf_e%0d", e),  32'(bus.overflow), 32'd0);
      chk($sformatf("clr_led_e%0d", e),  32'(bus.led_out),  32'(e <= 3));
      chk($sformatf("clr_busy_e%0d", e), 32'(bus.busy),     32'(e <= 6));
    end

    // Async reset mid-ON with pending=2
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_pre_pend", 32'(bus.pending), 32'd2);
    chk("rst_pre_led",  32'(bus.led_out), 32'd1);
    rst = 1'b0;
    #1;
    chk_idle("rst_async");
    @(posedge clk_in);
    #1;
    chk_idle("rst_held");
    rst = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step(1'b0, 1'b0);
      chk_idle($sformatf("rst_after_e%0d", e));
    end

    // A fresh pulse still works after reset
    step(1'b1, 1'b0);
    chk("rst_new_led",  32'(bus.led_out), 32'd1);
    chk("rst_new_busy", 32'(bus.busy),    32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
